// File: rtl/cm0_phase_sequencer.sv
// Multi-cycle control sequencer for the Cortex-M0 core: reset-vector fetch,
// fetch/decode/execute/memory/writeback phase strobes, memory req/ready handshake with a
// wait-state timeout, halt/resume, stall and a retired-instruction counter.
module cm0_phase_sequencer #(
  parameter int unsigned NUM_LD  = 7,
  parameter int unsigned PC_BIT  = 2,
  parameter int unsigned EXEC_W  = 3,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        addr_sel,
  input  logic              dec_is_mem,
  input  logic              dec_is_store,
  input  logic [EXEC_W-1:0] dec_exec_cycles,
  input  logic [NUM_LD-1:0] dec_ld_mask,
  input  logic              dec_halt,
  input  logic              stall,
  input  logic              resume,
  output logic              ph_fetch,
  output logic              ph_decode,
  output logic              ph_execute,
  output logic              ph_mem,
  output logic              ph_wb,
  output logic              ld_ir,
  output logic              ld_sp_vec,
  output logic              ld_pc_vec,
  output logic [NUM_LD-1:0] ld,
  output logic              pc_inc,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_count
);

  // Wait counter only needs to reach TIMEOUT; keep one bit when the timeout is disabled.
  localparam int unsigned WaitW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT);

  typedef enum logic [3:0] {
    StVecSp,
    StVecPc,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StHalt,
    StFault
  } state_e;

  state_e            state_q, state_d;
  logic [EXEC_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              is_mem_q, is_mem_d;
  logic              is_store_q, is_store_d;
  logic [NUM_LD-1:0] ld_mask_q, ld_mask_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic              timeout_hit;

  assign instr_count = instr_count_q;

  // A pending request that has waited TIMEOUT cycles faults unless ready arrives now.
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == TimeoutVal) && !mem_ready;

  // State and datapath-control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StVecSp;
      exec_cnt_q    <= '0;
      wait_q        <= '0;
      is_mem_q      <= 1'b0;
      is_store_q    <= 1'b0;
      ld_mask_q     <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      exec_cnt_q    <= exec_cnt_d;
      wait_q        <= wait_d;
      is_mem_q      <= is_mem_d;
      is_store_q    <= is_store_d;
      ld_mask_q     <= ld_mask_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state, counters and decode latches.
  always_comb begin
    state_d       = state_q;
    exec_cnt_d    = exec_cnt_q;
    is_mem_d      = is_mem_q;
    is_store_d    = is_store_q;
    ld_mask_d     = ld_mask_q;
    instr_count_d = instr_count_q;

    unique case (state_q)
      StVecSp: begin
        if (mem_ready)        state_d = StVecPc;
        else if (timeout_hit) state_d = StFault;
      end
      StVecPc: begin
        if (mem_ready)        state_d = StFetch;
        else if (timeout_hit) state_d = StFault;
      end
      StFetch: begin
        if (mem_ready)        state_d = StDecode;
        else if (timeout_hit) state_d = StFault;
      end
      StDecode: begin
        if (!stall) begin
          is_mem_d   = dec_is_mem;
          is_store_d = dec_is_store;
          ld_mask_d  = dec_ld_mask;
          // A zero cycle count behaves as a single execute cycle.
          exec_cnt_d = (dec_exec_cycles == '0) ? '0 : dec_exec_cycles - EXEC_W'(1);
          state_d    = dec_halt ? StHalt : StExecute;
        end
      end
      StExecute: begin
        if (!stall) begin
          if (exec_cnt_q == '0) state_d = is_mem_q ? StMem : StWb;
          else                  exec_cnt_d = exec_cnt_q - EXEC_W'(1);
        end
      end
      StMem: begin
        if (mem_ready)        state_d = StWb;
        else if (timeout_hit) state_d = StFault;
      end
      StWb: begin
        if (!stall) begin
          instr_count_d = instr_count_q + CNT_W'(1);
          state_d       = StFetch;
        end
      end
      StHalt: begin
        if (!stall && resume) state_d = StFetch;
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase

    // Wait count restarts on every state change and saturates at the timeout value.
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_req && !mem_ready && (wait_q != TimeoutVal)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  // Moore phase/request outputs and Mealy load pulses.
  always_comb begin
    ph_fetch   = 1'b0;
    ph_decode  = 1'b0;
    ph_execute = 1'b0;
    ph_mem     = 1'b0;
    ph_wb      = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 2'd0;
    ld_ir      = 1'b0;
    ld_sp_vec  = 1'b0;
    ld_pc_vec  = 1'b0;
    ld         = '0;
    pc_inc     = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      StVecSp: begin
        mem_req   = 1'b1;
        addr_sel  = 2'd2;
        ld_sp_vec = mem_ready;
      end
      StVecPc: begin
        mem_req   = 1'b1;
        addr_sel  = 2'd3;
        ld_pc_vec = mem_ready;
      end
      StFetch: begin
        ph_fetch = 1'b1;
        mem_req  = 1'b1;
        addr_sel = 2'd0;
        ld_ir    = mem_ready;
      end
      StDecode:  ph_decode  = 1'b1;
      StExecute: ph_execute = 1'b1;
      StMem: begin
        ph_mem   = 1'b1;
        mem_req  = 1'b1;
        mem_wr   = is_store_q;
        addr_sel = 2'd1;
      end
      StWb: begin
        ph_wb = 1'b1;
        if (!stall) begin
          ld     = ld_mask_q;
          pc_inc = ~ld_mask_q[PC_BIT];
        end
      end
      StHalt: begin
        halted = 1'b1;
        pc_inc = resume && !stall;
      end
      StFault: fault = 1'b1;
      default: ;
    endcase

    // The reset state is VEC_SP; keep its request quiet until reset is released.
    if (!rst) begin
      mem_req   = 1'b0;
      ld_sp_vec = 1'b0;
    end
  end

endmodule

// File: doc/cm0_phase_sequencer.md
Name: cm0_phase_sequencer

Overview:
Parametrised multi-cycle control sequencer for the Cortex-M0 core. It replaces the fixed-phase control unit.
- Runs the reset vector fetch (SP, then PC).
- Drives the fetch/decode/execute/memory/writeback phase strobes into the Datapath.
- Handshakes with memory through a req/ready pair with a wait-state timeout.
- Supports variable execute length, halt/resume, stall, and a retired-instruction counter.

Parameters:
NUM_LD, 7, width of the register load-strobe vector (sp, lr, pc, rd, apsr, ipsr, primask)
PC_BIT, 2, index in the load mask that corresponds to the PC; suppresses pc_inc
EXEC_W, 3, width of the execute cycle count
TIMEOUT, 15, maximum wait cycles on a memory request before a fault; 0 disables the timeout
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
mem_wr  out  1  request is a write
addr_sel  out  2  address source: 0 = PC, 1 = ALU result, 2 = vector 0x0, 3 = vector 0x4
dec_is_mem  in  1  decoded instruction accesses memory
dec_is_store  in  1  memory access is a store
dec_exec_cycles  in  EXEC_W  execute cycles; 0 is treated as 1
dec_ld_mask  in  NUM_LD  register load enables to apply at writeback
dec_halt  in  1  decoded instruction halts the core (BKPT/WFI)
stall  in  1  freeze the sequencer in non-memory states
resume  in  1  leave HALT
ph_fetch, ph_decode, ph_execute, ph_mem, ph_wb  out  1 each  one-hot phase indicators
ld_ir  out  1  one-cycle pulse: capture instruction
ld_sp_vec, ld_pc_vec  out  1 each  one-cycle pulses: capture vector words
ld  out  NUM_LD  one-cycle load strobes at writeback
pc_inc  out  1  one-cycle pulse: PC += 2
halted  out  1  FSM is in HALT
fault  out  1  sticky memory-timeout fault
instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to VEC_SP.
  - All pulses, phase indicators, halted, fault, instr_count, wait counter and execute counter are 0.
  - Latched decode fields are 0.
- Outputs: mem_req, mem_wr, addr_sel and phase indicators are Moore (decoded from state). Pulses are Mealy on the mem_ready completion, or state-decoded in WB.
- VEC_SP:
  - mem_req = 1, addr_sel = 2.
  - On mem_ready: ld_sp_vec pulses and the FSM goes to VEC_PC.
- VEC_PC:
  - mem_req = 1, addr_sel = 3.
  - On mem_ready: ld_pc_vec pulses and the FSM goes to FETCH.
- FETCH:
  - ph_fetch = 1, mem_req = 1, addr_sel = 0, mem_wr = 0.
  - On mem_ready: ld_ir pulses and the FSM goes to DECODE.
- DECODE (one cycle):
  - ph_decode = 1.
  - Latches exec_cycles (0 becomes 1), is_mem, is_store and ld_mask.
  - If dec_halt: go to HALT. Otherwise go to EXECUTE with the execute counter set to exec_cycles − 1.
- EXECUTE:
  - ph_execute = 1.
  - When the counter is 0: go to MEM if is_mem, else go to WB. Otherwise decrement the counter.
- MEM:
  - ph_mem = 1, mem_req = 1, addr_sel = 1, mem_wr = is_store.
  - On mem_ready: go to WB.
- WB (one cycle):
  - ph_wb = 1, ld = latched mask.
  - pc_inc = ~mask[PC_BIT].
  - instr_count increments.
  - Then go to FETCH.
- HALT:
  - halted = 1, no requests.
  - resume = 1 goes to FETCH, with pc_inc pulsed on the exit cycle.
- FAULT:
  - fault = 1, all strobes 0, no requests.
  - Sticky; only reset exits.
- Memory states (VEC_SP, VEC_PC, FETCH, MEM):
  - The wait counter clears on state entry and increments each cycle with mem_req = 1 and mem_ready = 0.
  - If TIMEOUT ≠ 0 and the counter equals TIMEOUT with mem_ready still 0, go to FAULT on the next edge.
  - mem_ready in the same cycle as the timeout condition wins: the request completes normally.
- stall:
  - In DECODE, EXECUTE, WB and HALT, the state and counters hold, ld/pc_inc/ld_ir are forced to 0, and phase indicators stay asserted.
  - Ignored in memory states, so an issued request always completes or times out.
  - stall and resume together in HALT: stall wins.
- mem_ready while mem_req = 0 is ignored.
- Reset mid-request drops mem_req immediately (asynchronously) and restarts the vector fetch.
- Exactly one ph_* is high in FETCH through WB; all ph_* are 0 in VEC_*, HALT and FAULT.

Test Plan:
1. Reset release, mem_ready tied 1 → VEC_SP and VEC_PC in 2 cycles with ld_sp_vec and ld_pc_vec single pulses; FETCH with addr_sel = 0 on cycle 3.
2. ALU op: exec_cycles = 3, is_mem = 0, mask = 0b0001000 → EXECUTE lasts exactly 3 cycles; WB ld = 0b0001000, pc_inc = 1, instr_count 0 → 1.
3. Store: is_mem = 1, is_store = 1, mem_ready delayed 4 cycles, TIMEOUT = 15 → mem_req/mem_wr held 5 cycles with addr_sel = 1, then WB; no fault.
4. Fetch with mem_ready held 0 → fault = 1 after 16 request cycles; stays 1 with no requests until rst low.
5. dec_halt = 1 → halted = 1, no mem_req; resume with stall = 1 stays halted; resume with stall = 0 → FETCH with pc_inc pulse.
6. Branch with mask[PC_BIT] = 1 → pc_inc = 0 in WB; with CNT_W = 4, the 16th retirement wraps instr_count from 15 to 0.
